// File: rtl/i2c_ctrl_pkg.sv
// Shared types and helpers for the I2C command scheduler.
// Holds the state encodings, the default command widths and a constant clog2.
package i2c_ctrl_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        P_IDLE,
        P_HOLD
    } push_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_POP,
        L_START,
        L_RUN
    } launch_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first request at or after the index that follows the last grant.
module rr_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [clog2(NUM_REQ)-1:0] i_last,
    input  logic                      i_en,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IDX_W = clog2(NUM_REQ);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Shares one i2c_master between several command requesters: arbitrated pushes
// into the master's command FIFO and paced pops with a start timeout.
module i2c_cmd_scheduler
    import i2c_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int START_TMO  = 64
)(
    input  logic                           clk,
    input  logic                           arst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_W-1:0]              data,
    output logic [ADDR_W-1:0]              addr,
    output logic                           fifo_wr_en,
    output logic                           fifo_rd_en,
    input  logic                           fifo_full,
    input  logic                           fifo_empty,
    input  logic                           fsm_ready,
    output logic [clog2(NUM_REQ)-1:0]      grant_id,
    output logic [clog2(FIFO_DEPTH):0]     occupancy,
    output logic                           busy,
    output logic                           tmo_err
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int OCC_W = clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = clog2(START_TMO) + 1;

    push_state_t      r_push_state, w_push_next;
    launch_state_t    r_launch_state, w_launch_next;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_last;
    logic               w_push_ok;
    logic               w_accept;
    logic               w_pop;
    logic               w_tmo_hit;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    logic [DATA_W-1:0]  r_data;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wr_en;
    logic [IDX_W-1:0]   r_grant_id;
    logic               r_granted_once;
    logic [OCC_W-1:0]   r_occupancy;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_tmo_err;

    // Until the first grant the search must start at index 0, so pretend the last winner was the top index.
    assign w_last    = r_granted_once ? r_grant_id : IDX_W'(NUM_REQ - 1);
    assign w_push_ok = !arst && (r_push_state == P_IDLE) && !fifo_full &&
                       (r_occupancy < OCC_W'(FIFO_DEPTH));
    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .i_req   (req_valid),
        .i_last  (w_last),
        .i_en    (w_push_ok),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_push_state <= P_IDLE;
        end else begin
            r_push_state <= w_push_next;
        end
    end

    always_comb begin
        w_push_next = r_push_state;
        case (r_push_state)
            P_IDLE:  if (w_accept) w_push_next = P_HOLD;
            P_HOLD:  w_push_next = P_IDLE;
            default: w_push_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_data         <= '0;
            r_addr         <= '0;
            r_wr_en        <= 1'b0;
            r_grant_id     <= '0;
            r_granted_once <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_data         <= w_sel_data;
                r_addr         <= w_sel_addr;
                r_grant_id     <= w_grant_idx;
                r_granted_once <= 1'b1;
            end
        end
    end

    // A desynced FIFO (empty while we still count entries) simply parks the launcher in idle.
    assign w_pop     = (r_launch_state == L_IDLE) && (r_occupancy != '0) && !fifo_empty && fsm_ready;
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(START_TMO - 1));

    always_ff @(posedge clk) begin
        if (arst) begin
            r_launch_state <= L_IDLE;
        end else begin
            r_launch_state <= w_launch_next;
        end
    end

    always_comb begin
        w_launch_next = r_launch_state;
        case (r_launch_state)
            L_IDLE:  if (w_pop) w_launch_next = L_POP;
            L_POP:   w_launch_next = L_START;
            L_START: begin
                if (!fsm_ready) begin
                    w_launch_next = L_RUN;
                end else if (w_tmo_hit) begin
                    w_launch_next = L_IDLE;
                end
            end
            L_RUN:   if (fsm_ready) w_launch_next = L_IDLE;
            default: w_launch_next = L_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = (r_launch_state == L_POP);
        busy       = (r_launch_state != L_IDLE);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_launch_state == L_START) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                if (fsm_ready && w_tmo_hit) begin
                    r_tmo_err <= 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    // Counts at the edge that raises each strobe, so it moves together with wr_en/rd_en.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_occupancy <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
                2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign data       = r_data;
    assign addr       = r_addr;
    assign fifo_wr_en = r_wr_en;
    assign grant_id   = r_grant_id;
    assign occupancy  = r_occupancy;
    assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Directed bench for i2c_cmd_scheduler: reset, pushes, round robin, backpressure,
// launch pacing, FIFO desync, start timeout and reset recovery.
module tb_i2c_cmd_scheduler;

    logic        clk;
    logic        arst;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  data;
    logic [6:0]  addr;
    logic        fifo_wr_en;
    logic        fifo_rd_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fsm_ready;
    logic [1:0]  grant_id;
    logic [4:0]  occupancy;
    logic        busy;
    logic        tmo_err;

    int checks = 0;
    int errors = 0;

    i2c_cmd_scheduler dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .data       (data),
        .addr       (addr),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fsm_ready  (fsm_ready),
        .grant_id   (grant_id),
        .occupancy  (occupancy),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic full, input logic empty, input logic ready);
        req_valid  = valid;
        fifo_full  = full;
        fifo_empty = empty;
        fsm_ready  = ready;
        #1;
    endtask

    task automatic setPayload(input int idx, input logic [6:0] a, input logic [7:0] d);
        req_addr[idx*7 +: 7] = a;
        req_data[idx*8 +: 8] = d;
    endtask

    task automatic applyReset();
        arst = 1'b1;
        tick(1);
        arst = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] expGrant;
        arst       = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        fsm_ready  = 1'b0;

        // Reset state
        applyReset();
        checkOutput("rst_data", data, 8'h00);
        checkOutput("rst_addr", addr, 7'h00);
        checkOutput("rst_grant", grant_id, 2'd0);
        checkOutput("rst_occ", occupancy, 5'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_tmo", tmo_err, 1'b0);
        checkOutput("rst_ready", req_ready, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            checkOutput("rst_idle_strobes", {fifo_wr_en, fifo_rd_en}, 2'b00);
            tick(1);
        end

        // Single push from requester 1
        setPayload(1, 7'h3A, 8'hC5);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("single_ready", req_ready, 4'b0010);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("single_wr", fifo_wr_en, 1'b1);
        checkOutput("single_addr", addr, 7'h3A);
        checkOutput("single_data", data, 8'hC5);
        checkOutput("single_grant", grant_id, 2'd1);
        checkOutput("single_occ", occupancy, 5'd1);
        tick(1);
        checkOutput("single_wr_drop", fifo_wr_en, 1'b0);
        checkOutput("single_data_hold", data, 8'hC5);

        // Round robin with all four requesters valid
        applyReset();
        for (int i = 0; i < 4; i++) begin
            setPayload(i, 7'(8'h10 + i), 8'(8'hA0 + i));
        end
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            expGrant = 4'b0001 << (k % 4);
            checkOutput("rr_ready", req_ready, expGrant);
            tick(1);
            checkOutput("rr_wr", fifo_wr_en, 1'b1);
            checkOutput("rr_grant", grant_id, k % 4);
            checkOutput("rr_addr", addr, 8'h10 + (k % 4));
            checkOutput("rr_data", data, 8'hA0 + (k % 4));
            checkOutput("rr_occ", occupancy, k + 1);
            checkOutput("rr_hold_ready", req_ready, 4'b0000);
            tick(1);
            checkOutput("rr_wr_gap", fifo_wr_en, 1'b0);
        end

        // Backpressure from fifo_full
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_ready", req_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("bp_wr", fifo_wr_en, 1'b0);
        end
        checkOutput("bp_occ", occupancy, 5'd5);
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_release_ready", req_ready, 4'b0010);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_release_wr", fifo_wr_en, 1'b1);
        checkOutput("bp_release_grant", grant_id, 2'd1);
        checkOutput("bp_release_occ", occupancy, 5'd6);
        tick(1);

        // Launch pacing: two entries, master busy for 20 cycles between pops
        applyReset();
        setPayload(0, 7'h05, 8'h50);
        setPayload(2, 7'h25, 8'h52);
        applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
        tick(4);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("launch_occ2", occupancy, 5'd2);
        checkOutput("launch_grant", grant_id, 2'd2);
        checkOutput("launch_data_last", data, 8'h52);
        checkOutput("launch_idle_rd", fifo_rd_en, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("pop1_rd", fifo_rd_en, 1'b1);
        checkOutput("pop1_busy", busy, 1'b1);
        checkOutput("pop1_occ", occupancy, 5'd1);
        tick(1);
        checkOutput("pop1_rd_drop", fifo_rd_en, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(20);
        checkOutput("run_busy", busy, 1'b1);
        checkOutput("run_rd", fifo_rd_en, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("run_done_busy", busy, 1'b0);
        checkOutput("run_done_rd", fifo_rd_en, 1'b0);
        tick(1);
        checkOutput("pop2_rd", fifo_rd_en, 1'b1);
        checkOutput("pop2_occ", occupancy, 5'd0);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("drain_busy", busy, 1'b0);
        tick(2);
        checkOutput("drain_no_pop", fifo_rd_en, 1'b0);
        checkOutput("drain_tmo", tmo_err, 1'b0);

        // FIFO desync: empty while an entry is counted blocks the pop
        applyReset();
        setPayload(3, 7'h7F, 8'hFF);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("desync_occ", occupancy, 5'd1);
        checkOutput("desync_grant", grant_id, 2'd3);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("desync_no_pop", {busy, fifo_rd_en}, 2'b00);
        end

        // Start timeout: master never drops fsm_ready after the pop
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("tmo_pop_rd", fifo_rd_en, 1'b1);
        checkOutput("tmo_pop_occ", occupancy, 5'd0);
        tick(1);
        tick(63);
        checkOutput("tmo_before", tmo_err, 1'b0);
        checkOutput("tmo_before_busy", busy, 1'b1);
        tick(1);
        checkOutput("tmo_set", tmo_err, 1'b1);
        checkOutput("tmo_set_busy", busy, 1'b0);
        tick(3);
        checkOutput("tmo_sticky", tmo_err, 1'b1);

        // Reset in the middle of a running transaction
        setPayload(0, 7'h11, 8'h22);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_grant", grant_id, 2'd0);
        tick(1);
        checkOutput("mid_pop_rd", fifo_rd_en, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(1);
        setPayload(1, 7'h33, 8'h44);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_run_busy", busy, 1'b1);
        checkOutput("mid_occ", occupancy, 5'd1);
        checkOutput("mid_grant2", grant_id, 2'd1);
        applyReset();
        checkOutput("mid_rst_tmo", tmo_err, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_occ", occupancy, 5'd0);
        checkOutput("mid_rst_grant", grant_id, 2'd0);
        checkOutput("mid_rst_payload", {addr, data}, 15'h0000);
        checkOutput("mid_rst_strobes", {fifo_wr_en, fifo_rd_en}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
